// File: rtl/sig_pulse_pair_pkg.sv
// Shared definitions for the comparator edge timestamper and the pulse
// pairing stage. Both stages import this package, so they agree on the
// timestamp width and the pairing FSM encoding.
package sig_pulse_pair_pkg;

    // Default timestamp width. The upstream sig_time width must match it.
    localparam int unsigned TS_W_DEF = 32;

    // Pairing FSM: IDLE waits for a rise; HIGH holds an open pulse.
    typedef enum logic {
        IDLE = 1'b0,
        HIGH = 1'b1
    } state_e;

endpackage

// File: rtl/sig_pulse_fifo.sv
// sig_pulse_fifo: parameterised first-word-fall-through synchronous FIFO
// that holds packed pulse records.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   wr_en/wr_data write request and record; when full, the write is
//                 accepted only if a read happens in the same cycle
//   rd_en         advance the head; ignored while empty
//   rd_data       head record, driven straight from storage
//   full, empty   occupancy flags
//   level         exact occupancy, 0..DEPTH
module sig_pulse_fifo #(
    parameter int unsigned DW    = 48,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [DW-1:0]    wr_data,
    input  logic             rd_en,
    output logic [DW-1:0]    rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [AW-1:0]    head_idx;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign level   = level_q;
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);

    // While empty, present the slot just popped so the head output keeps its
    // last value. That slot cannot be rewritten until the FIFO fills around,
    // which requires it to be non-empty first. After reset every slot is zero.
    always_comb begin
        head_idx = rd_ptr_q;
        if (empty) begin
            head_idx = rd_ptr_q - AW'(1);
        end
    end

    assign rd_data = mem_q[head_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/sig_pulse_pair.sv
// sig_pulse_pair: pairs each rise timestamp with the next fall into a pulse
// record {start, width}. Pulses shorter than MIN_WIDTH are dropped. Accepted
// records are queued in a FWFT FIFO and drained over valid/ready. Keeps a
// per-scan accepted-record counter and a sticky overflow flag.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   sync_start    scan start: FSM to IDLE, clears pulse_cnt/overflow, the
//                 cycle's strobes are ignored; FIFO contents are kept
//   sig_rise      rising-edge strobe
//   sig_fall      falling-edge strobe (wins over a same-cycle rise)
//   sig_time      timestamp accompanying the strobe
//   pulse_valid   FIFO head holds a record
//   pulse_ready   consumer takes the head record
//   pulse_start   head record rise timestamp
//   pulse_width   head record width, saturated to all-ones
//   pulse_cnt     records written this scan, saturating
//   overflow      sticky: an accepted record was lost to a full FIFO
//   fifo_level    FIFO occupancy
module sig_pulse_pair
    import sig_pulse_pair_pkg::*;
#(
    parameter int unsigned TS_W       = TS_W_DEF,
    parameter int unsigned W_W        = 16,
    parameter int unsigned MIN_WIDTH  = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sync_start,
    input  logic                        sig_rise,
    input  logic                        sig_fall,
    input  logic [TS_W-1:0]             sig_time,
    output logic                        pulse_valid,
    input  logic                        pulse_ready,
    output logic [TS_W-1:0]             pulse_start,
    output logic [W_W-1:0]              pulse_width,
    output logic [CNT_W-1:0]            pulse_cnt,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned DW    = TS_W + W_W;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TS_W-1:0] MIN_TS = TS_W'(MIN_WIDTH);

    state_e           state_q, state_d;
    logic [TS_W-1:0]  start_q, start_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [TS_W-1:0]  diff;
    logic [W_W-1:0]   width_sat;
    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DW-1:0]    head;

    // Modular subtraction handles a timer wrap between rise and fall.
    assign diff = sig_time - start_q;

    always_comb begin
        width_sat = diff[W_W-1:0];
        if ((diff >> W_W) != '0) begin
            width_sat = '1;
        end
    end

    assign pop = pulse_valid && pulse_ready;

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        push_req = 1'b0;
        push_ok  = 1'b0;
        if (sync_start) begin
            state_d = IDLE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A fall here is an orphan; a same-cycle rise loses to it.
                    if (sig_rise && !sig_fall) begin
                        start_d = sig_time;
                        state_d = HIGH;
                    end
                end
                HIGH: begin
                    if (sig_fall) begin
                        state_d  = IDLE;
                        push_req = (diff >= MIN_TS);
                    end else if (sig_rise) begin
                        start_d = sig_time;
                    end
                end
                default: state_d = IDLE;
            endcase
            // A full FIFO still takes the record if the head leaves this cycle.
            push_ok = push_req && (!fifo_full || pop);
            if (push_ok) begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (push_req) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            start_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    sig_pulse_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (push_ok),
        .wr_data ({start_q, width_sat}),
        .rd_en   (pulse_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign pulse_valid = !fifo_empty;
    assign pulse_start = head[DW-1:W_W];
    assign pulse_width = head[W_W-1:0];
    assign pulse_cnt   = cnt_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_sig_pulse_pair.sv
// Testbench for sig_pulse_pair: directed edge sequences, a record-level
// reference model checked every cycle, and literal expectations per scenario.
module tb_sig_pulse_pair;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sync_start = 1'b0;
    logic        sig_rise = 1'b0;
    logic        sig_fall = 1'b0;
    logic [31:0] sig_time = '0;
    logic        pulse_valid;
    logic        pulse_ready = 1'b0;
    logic [31:0] pulse_start;
    logic [15:0] pulse_width;
    logic [7:0]  pulse_cnt;
    logic        overflow;
    logic [3:0]  fifo_level;

    sig_pulse_pair #(
        .TS_W       (32),
        .W_W        (16),
        .MIN_WIDTH  (4),
        .FIFO_DEPTH (8),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sync_start  (sync_start),
        .sig_rise    (sig_rise),
        .sig_fall    (sig_fall),
        .sig_time    (sig_time),
        .pulse_valid (pulse_valid),
        .pulse_ready (pulse_ready),
        .pulse_start (pulse_start),
        .pulse_width (pulse_width),
        .pulse_cnt   (pulse_cnt),
        .overflow    (overflow),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] s;
        logic [15:0] w;
    } rec_t;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a record queue with at most 8 entries, an optional
    // open pulse start, a saturating record count and a sticky loss flag.
    rec_t        m_q[$];
    bit          m_open = 0;
    logic [31:0] m_st = '0;
    int          m_cnt = 0;
    bit          m_ovf = 0;
    bit          m_pop, m_req;
    rec_t        m_rec;
    logic [31:0] m_d;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_open = 0;
            m_st   = '0;
            m_cnt  = 0;
            m_ovf  = 0;
        end else begin
            m_pop = (m_q.size() > 0) && pulse_ready;
            m_req = 0;
            if (sync_start) begin
                m_open = 0;
                m_cnt  = 0;
                m_ovf  = 0;
            end else if (sig_fall) begin
                if (m_open) begin
                    m_d    = sig_time - m_st;
                    m_open = 0;
                    if (m_d >= 4) begin
                        m_req   = 1;
                        m_rec.s = m_st;
                        m_rec.w = (m_d > 32'd65535) ? 16'hFFFF : m_d[15:0];
                    end
                end
            end else if (sig_rise) begin
                m_open = 1;
                m_st   = sig_time;
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_req) begin
                if (m_q.size() < 8) begin
                    m_q.push_back(m_rec);
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    m_ovf = 1;
                end
            end
        end
    end

    // Per-cycle compare against the model, plus a log of records the DUT hands out.
    rec_t got[$];

    always @(negedge clk) begin
        chk("valid", pulse_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("head_start", pulse_start, m_q[0].s);
            chk("head_width", pulse_width, m_q[0].w);
        end
        chk("level", fifo_level, m_q.size());
        chk("cnt", pulse_cnt, m_cnt);
        chk("overflow", overflow, m_ovf);
        if (pulse_valid && pulse_ready) got.push_back({pulse_start, pulse_width});
    end

    task automatic cyc(input logic r, input logic f, input logic s, input logic [31:0] t);
        sig_rise   = r;
        sig_fall   = f;
        sync_start = s;
        sig_time   = t;
        @(posedge clk);
        #1;
        sig_rise   = 1'b0;
        sig_fall   = 1'b0;
        sync_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [31:0] ts, input logic [31:0] te);
        cyc(1'b1, 1'b0, 1'b0, ts);
        cyc(1'b0, 1'b1, 1'b0, te);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_valid", pulse_valid, 0);
        chk("rst_start", pulse_start, 0);
        chk("rst_width", pulse_width, 0);
        chk("rst_cnt", pulse_cnt, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_level", fifo_level, 0);

        // 1: basic pulse, visible exactly one cycle after the fall
        pulse_ready = 1'b1;
        got.delete();
        pulse(32'd100, 32'd150);
        @(negedge clk);
        chk("t1_valid", pulse_valid, 1);
        chk("t1_start", pulse_start, 100);
        chk("t1_width", pulse_width, 50);
        chk("t1_cnt", pulse_cnt, 1);
        chk("t1_model_cnt", m_cnt, 1);
        idle(1);
        @(negedge clk);
        chk("t1_valid_gone", pulse_valid, 0);
        chk("t1_nrec", got.size(), 1);

        // 2: glitch below MIN_WIDTH dropped, exactly MIN_WIDTH kept
        idle(1);
        got.delete();
        pulse(32'd200, 32'd203);
        pulse(32'd300, 32'd304);
        idle(2);
        chk("t2_nrec", got.size(), 1);
        if (got.size() == 1) chk("t2_rec", got[0], {32'd300, 16'd4});
        chk("t2_cnt", pulse_cnt, 2);

        // 3: timestamp wrap and width saturation
        got.delete();
        pulse(32'hFFFF_FFF0, 32'h0000_0010);
        pulse(32'd0, 32'd70000);
        idle(2);
        chk("t3_nrec", got.size(), 2);
        if (got.size() == 2) begin
            chk("t3_wrap", got[0], {32'hFFFF_FFF0, 16'h0020});
            chk("t3_sat", got[1], {32'd0, 16'hFFFF});
        end
        chk("t3_cnt", pulse_cnt, 4);

        // 4: orphan fall ignored, missed fall recaptures start; rise+fall together in IDLE ignored
        got.delete();
        cyc(1'b0, 1'b1, 1'b0, 32'd10);
        cyc(1'b1, 1'b1, 1'b0, 32'd12);
        cyc(1'b1, 1'b0, 1'b0, 32'd20);
        cyc(1'b1, 1'b0, 1'b0, 32'd30);
        cyc(1'b0, 1'b1, 1'b0, 32'd45);
        idle(2);
        chk("t4_nrec", got.size(), 1);
        if (got.size() == 1) chk("t4_rec", got[0], {32'd30, 16'd15});
        chk("t4_cnt", pulse_cnt, 5);

        // 5: overflow with consumer stalled, then ordered drain
        cyc(1'b0, 1'b0, 1'b1, 32'd0);
        chk("t5_sync_cnt", pulse_cnt, 0);
        pulse_ready = 1'b0;
        for (int i = 0; i < 9; i++) pulse(32'd1000 + 32'(100 * i), 32'd1010 + 32'(101 * i));
        idle(1);
        chk("t5_level", fifo_level, 8);
        chk("t5_ovf", overflow, 1);
        chk("t5_cnt", pulse_cnt, 8);
        got.delete();
        pulse_ready = 1'b1;
        idle(10);
        pulse_ready = 1'b0;
        chk("t5_nrec", got.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) chk("t5_rec", got[i], {32'd1000 + 32'(100 * i), 16'(10 + i)});
        end
        chk("t5_level_end", fifo_level, 0);

        // 6a: sync mid-pulse; FIFO contents survive and drain
        pulse(32'd600, 32'd620);
        pulse(32'd700, 32'd730);
        cyc(1'b1, 1'b0, 1'b0, 32'd500);
        cyc(1'b0, 1'b0, 1'b1, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'd40);
        idle(1);
        chk("t6_cnt", pulse_cnt, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_level", fifo_level, 2);
        got.delete();
        pulse_ready = 1'b1;
        idle(4);
        chk("t6_nrec", got.size(), 2);
        if (got.size() == 2) begin
            chk("t6_rec0", got[0], {32'd600, 16'd20});
            chk("t6_rec1", got[1], {32'd700, 16'd30});
        end

        // 6b: asynchronous reset in the middle of a drain
        pulse_ready = 1'b0;
        pulse(32'd800, 32'd810);
        pulse(32'd900, 32'd920);
        pulse(32'd1000, 32'd1030);
        pulse_ready = 1'b1;
        idle(1);
        chk("t6b_valid_pre", pulse_valid, 1);
        chk("t6b_level_pre", fifo_level, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6b_valid_rst", pulse_valid, 0);
        chk("t6b_level_rst", fifo_level, 0);
        chk("t6b_start_rst", pulse_start, 0);
        pulse_ready = 1'b0;
        #3;
        reset_n = 1'b1;
        idle(2);
        chk("t6b_cnt_end", pulse_cnt, 0);
        chk("t6b_valid_end", pulse_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
